// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store memory responder.
// Misalignment checking is only used when MEM_MISALIGN_TRAP_EN is defined.
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_D  = 3'b011,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101,
        MEM_WU = 3'b110
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WRITE,
        RESP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Stores only have sb/sh/sw/sd; loads reject only 111.
    function automatic logic func3_illegal(input logic we, input logic [2:0] func3);
        return we ? func3[2] : (func3 == 3'b111);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] func3, input logic [2:0] lo);
        logic mis;
        case (func3[1:0])
            2'd1:    mis = lo[0];
            2'd2:    mis = |lo[1:0];
            2'd3:    mis = |lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Lane extraction with sign/zero extension for loads, and byte-lane merge
// of store data into a RAM word for read-modify-write stores.
module load_store_align
    import mem_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  addr_lo,
    input  logic [2:0]  func3,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] store_word
);

    logic [2:0]  lane_off;
    logic [3:0]  lane_bytes;
    logic [63:0] lane_data;
    logic [63:0] wdata_shift;
    logic [7:0]  byte_en;

    // Low address bits below the access size are ignored, so the lane
    // offset is the address rounded down to the access size.
    always_comb begin
        lane_off   = 3'd0;
        lane_bytes = 4'd8;
        case (func3[1:0])
            2'd0: begin
                lane_off   = addr_lo;
                lane_bytes = 4'd1;
            end
            2'd1: begin
                lane_off   = {addr_lo[2:1], 1'b0};
                lane_bytes = 4'd2;
            end
            2'd2: begin
                lane_off   = {addr_lo[2], 2'b00};
                lane_bytes = 4'd4;
            end
            default: begin
                lane_off   = 3'd0;
                lane_bytes = 4'd8;
            end
        endcase
    end

    assign lane_data   = word >> {lane_off, 3'b000};
    assign wdata_shift = wdata << {lane_off, 3'b000};

    always_comb begin
        load_data = lane_data;
        case (func3)
            MEM_B:   load_data = {{56{lane_data[7]}},  lane_data[7:0]};
            MEM_H:   load_data = {{48{lane_data[15]}}, lane_data[15:0]};
            MEM_W:   load_data = {{32{lane_data[31]}}, lane_data[31:0]};
            MEM_BU:  load_data = {56'd0, lane_data[7:0]};
            MEM_HU:  load_data = {48'd0, lane_data[15:0]};
            MEM_WU:  load_data = {32'd0, lane_data[31:0]};
            default: load_data = lane_data;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign byte_en[gi] = (4'(gi) >= {1'b0, lane_off}) &&
                                 (4'(gi) < ({1'b0, lane_off} + lane_bytes));
            assign store_word[gi*8 +: 8] = byte_en[gi] ? wdata_shift[gi*8 +: 8]
                                                       : word[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store responder: word read, lane extract/extend, RMW sub-word stores.
// Define MEM_MISALIGN_TRAP_EN to turn misaligned accesses into error responses.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [ADDR_W-4:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state_reg;
    logic              we_reg;
    logic [2:0]        func3_reg;
    logic [2:0]        addr_lo_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_word;
    logic              req_err;

    load_store_align u_align (
        .word       (ram_rdata),
        .addr_lo    (addr_lo_reg),
        .func3      (func3_reg),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .store_word (store_word)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign req_err = func3_illegal(req_we, req_func3) ||
                     is_misaligned(req_func3, req_addr[2:0]);
`else
    assign req_err = func3_illegal(req_we, req_func3);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            we_reg      <= 1'b0;
            func3_reg   <= 3'd0;
            addr_lo_reg <= 3'd0;
            wdata_reg   <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            busy        <= 1'b0;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_wdata   <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            ram_we     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg      <= req_we;
                        func3_reg   <= req_func3;
                        addr_lo_reg <= req_addr[2:0];
                        wdata_reg   <= req_wdata;
                        ram_addr    <= req_addr[ADDR_W-1:3];
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        if (req_err) begin
                            state_reg  <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_we && req_func3 == MEM_D) begin
                            // Full doubleword store needs no read-back.
                            state_reg <= WRITE;
                            ram_we    <= 1'b1;
                            ram_wdata <= req_wdata;
                        end else begin
                            state_reg <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: state_reg <= RD_DATA;
                RD_DATA: begin
                    if (we_reg) begin
                        state_reg <= WRITE;
                        ram_we    <= 1'b1;
                        ram_wdata <= store_word;
                    end else begin
                        state_reg  <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end
                end
                WRITE: begin
                    state_reg  <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end
                RESP: begin
                    state_reg <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side responder for the multicycle RISC-V core's load/store traffic.
- The control FSM issues one request per ld/lw/lh/lb/lbu/lhu/lwu/sd/sw/sh/sb. This block does the word read, sub-word extraction and sign/zero extension.
- Sub-word stores are done as read-modify-write on a 64-bit-wide synchronous RAM.
- Sits between the control unit/datapath (AOut address, B store data, MDR load data) and the data RAM.

Parameters:
- ADDR_W, 32, byte-address width; RAM word index is addr[ADDR_W-1:3].
- DATA_W, 64, RAM word and register width; fixed at 64 (RV64 doubleword).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1=store, 0=load.
- req_func3  in  3  RISC-V func3 size/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  store data; low bytes used for sub-word stores.
- resp_valid  out  1  one-cycle pulse: access complete.
- resp_rdata  out  64  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; illegal func3 or misaligned access.
- busy  out  1  high in every non-IDLE state.
- ram_addr  out  ADDR_W-3  RAM word index, registered.
- ram_we  out  1  RAM write strobe, registered.
- ram_wdata  out  64  RAM write word, registered.
- ram_rdata  in  64  RAM read data, valid the cycle after ram_addr is sampled.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, ram_addr=0, ram_we=0, ram_wdata=0. All internal latches are cleared.
- Handshake: a request is accepted on a rising edge with req_valid&req_ready. At that edge, addr, func3, wdata and we are latched. req_ready=1 only in IDLE.
- States:
  - IDLE.
  - RD_ADDR: RAM samples ram_addr.
  - RD_DATA: ram_rdata captured into the data register; extracted for a load, merged for a store.
  - WRITE: ram_we=1 for exactly one cycle.
  - RESP: resp_valid=1 for one cycle, then IDLE.
- Transitions:
  - Load: IDLE→RD_ADDR→RD_DATA→RESP.
  - sd: IDLE→WRITE→RESP.
  - sb/sh/sw: IDLE→RD_ADDR→RD_DATA→WRITE→RESP.
  - Error: IDLE→RESP with resp_err=1; no RAM write.
- Latency, counted from the accepting edge: resp_valid is high in cycle 3 for loads, cycle 2 for sd, cycle 4 for sub-word stores, cycle 1 for errors.
- func3 for loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu. func3 111 is an error.
- func3 for stores: 000 sb, 001 sh, 010 sw, 011 sd. Store func3 ≥100 is an error.
- Lane select:
  - byte: lane addr[2:0].
  - half: addr[2:1] selects the half; addr[0] is ignored.
  - word: addr[2] selects the word; addr[1:0] are ignored.
  - doubleword: addr[2:0] are ignored.
- Signed loads sign-extend from the selected lane's MSB. lbu/lhu/lwu zero-extend.
- Merge: only the selected lane bytes are replaced by req_wdata low bytes; all other bytes keep the RAM value.
- resp_rdata holds its value until the next RESP. resp_err is 0 except during an error RESP.
- A new req_valid during any non-IDLE state is not accepted; it is accepted in the following IDLE cycle.
- Reset mid-operation: return to IDLE next edge.
  - If reset is asserted in the cycle before WRITE, ram_we never asserts.
  - If reset coincides with WRITE, that write completes (RAM samples the same edge) but no resp_valid follows.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a half/word/doubleword access whose address is not naturally aligned (addr[0], addr[1:0], addr[2:0] ≠ 0 respectively) goes IDLE→RESP with resp_err=1 and resp_rdata=0; no RAM read or write.
- Undefined: ignored low address bits as listed under Lane select; misaligned access never sets resp_err.

Decomposition:
- Package mem_pkg holds:
  - func3 size enum: MEM_B=3'b000, MEM_H, MEM_W, MEM_D, MEM_BU, MEM_HU, MEM_WU.
  - state enum: IDLE, RD_ADDR, RD_DATA, WRITE, RESP.
  - opcode constants OP_LOAD=7'b0000011, OP_STORE=7'b0100011.
- One combinational sub-module, load_store_align, computes the extracted/extended load value and the merged store word from (word, addr[2:0], func3, wdata).

Test Plan:
- RAM[1]=64'h8899AABBCCDDEEFF; lb addr 0x0F → resp_valid in cycle 3, rdata=64'hFFFFFFFFFFFFFF88, err=0.
- Same RAM; lhu addr 0x0C → rdata=64'h000000000000AABB; lw addr 0x08 → rdata=64'hFFFFFFFFCCDDEEFF.
- RAM[0]=64'h1111111111111111; sb addr 0x03, wdata 0xAB → ram_we one cycle in cycle 3; RAM[0]=64'h11111111AB111111; resp_valid in cycle 4.
- sd addr 0x10, wdata 64'hDEADBEEFCAFEF00D → exactly one ram_we, ram_addr=2, resp_valid in cycle 2; req_valid held high is accepted again only after RESP.
- Load func3=111 → resp_valid in cycle 1, resp_err=1, rdata=0, no RAM access. With MEM_MISALIGN_TRAP_EN, lw addr 0x06 → err=1; without it, lw addr 0x06 returns the upper word of RAM[0].
- sh accepted, reset asserted during RD_DATA → next cycle IDLE, req_ready=1, ram_we never high, RAM unchanged, no resp_valid.
